// File: rtl/mul_accum.sv
// Sequential signed multiply-accumulate: acc_out = acc_in + a*b (mod 2^ACC_WID),
// one shift-add step per cycle on operand magnitudes, with signed overflow flag.
//
// state    | meaning
// ---------+----------------------------------------------------------
// WAIT_ARM | idle; latches operands when arm is sampled high
// CALC     | unsigned shift-add, one bit of |b| per cycle, B_WID cycles
// ADD      | phase 0: apply product sign; phase 1: add acc_in, register result
// DONE     | finished high, result held until arm sampled low
module mul_accum #(
    parameter int A_WID   = 32,
    parameter int B_WID   = 32,
    parameter int ACC_WID = 64
) (
    input  logic               clk,
    input  logic               rst_L,
    input  logic               arm,
    input  logic [A_WID-1:0]   a,
    input  logic [B_WID-1:0]   b,
    input  logic [ACC_WID-1:0] acc_in,
    output logic [ACC_WID-1:0] acc_out,
    output logic               ovf,
    output logic               finished
);

    localparam int PW = A_WID + B_WID;
    localparam int CW = $clog2(B_WID + 1);

    typedef enum logic [1:0] {WAIT_ARM, CALC, ADD, DONE} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        prod;
    logic [PW-1:0]        mcand;
    logic [B_WID:0]       mplier;
    logic                 sign;
    logic [CW-1:0]        cnt;
    logic                 add_ph;
    logic [ACC_WID-1:0]   acc_lat;

    logic [A_WID:0]       a_ext, a_abs;
    logic [B_WID:0]       b_ext, b_abs;
    logic [ACC_WID-1:0]   p_ext, sum;

    // One extra bit keeps |most-negative| representable.
    assign a_ext = {a[A_WID-1], a};
    assign b_ext = {b[B_WID-1], b};
    assign a_abs = a[A_WID-1] ? -a_ext : a_ext;
    assign b_abs = b[B_WID-1] ? -b_ext : b_ext;

    assign p_ext    = ACC_WID'($signed(prod));
    assign sum      = acc_lat + p_ext;
    assign finished = (state == DONE);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) state <= WAIT_ARM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_ARM: if (arm)            state_nxt = CALC;
            CALC:     if (cnt == CW'(1))  state_nxt = ADD;
            ADD:      if (add_ph)         state_nxt = DONE;
            DONE:     if (!arm)           state_nxt = WAIT_ARM;
            default:                      state_nxt = WAIT_ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            sign    <= 1'b0;
            cnt     <= '0;
            add_ph  <= 1'b0;
            acc_lat <= '0;
            acc_out <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                WAIT_ARM: begin
                    if (arm) begin
                        mcand   <= PW'(a_abs);
                        mplier  <= b_abs;
                        sign    <= a[A_WID-1] ^ b[B_WID-1];
                        acc_lat <= acc_in;
                        prod    <= '0;
                        cnt     <= CW'(B_WID);
                        add_ph  <= 1'b0;
                    end
                end
                CALC: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                end
                ADD: begin
                    // Negate and add in separate cycles so the two wide carry chains never chain.
                    if (!add_ph) begin
                        if (sign) prod <= -prod;
                        add_ph <= 1'b1;
                    end else begin
                        acc_out <= sum;
                        ovf     <= (acc_lat[ACC_WID-1] == p_ext[ACC_WID-1]) &&
                                   (sum[ACC_WID-1] != acc_lat[ACC_WID-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_accum.sv
// Self-checking bench for mul_accum: fixed vector table, randomized operands
// against a wide-arithmetic reference, plus hold, abort and reset sequences.
module tb_mul_accum;

    logic        clk;
    logic        rst_L;
    logic        arm;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc_in;
    logic [63:0] acc_out;
    logic        ovf;
    logic        finished;

    int pass_cnt = 0;
    int total_cnt = 0;

    mul_accum #(.A_WID(32), .B_WID(32), .ACC_WID(64)) dut (
        .clk      (clk),
        .rst_L    (rst_L),
        .arm      (arm),
        .a        (a),
        .b        (b),
        .acc_in   (acc_in),
        .acc_out  (acc_out),
        .ovf      (ovf),
        .finished (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        logic [63:0] eo;
        logic        eovf;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    // Reference: exact product and sum in 66 bits, overflow if the sum does not fit in 64.
    task automatic model(input logic [31:0] ta, input logic [31:0] tb, input logic [63:0] tacc,
                         output logic [63:0] eo, output logic eovf);
        longint p;
        logic signed [65:0] w;
        p = longint'($signed(ta)) * longint'($signed(tb));
        w = $signed(tacc) + $signed(p);
        eo = w[63:0];
        eovf = (w[65:63] != {3{w[63]}});
    endtask

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [63:0] tacc,
                         input logic [63:0] eo, input logic eovf,
                         input bit scr, input bit drop, input string nm);
        int n;
        @(negedge clk);
        a = ta; b = tb; acc_in = tacc; arm = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (drop) arm = 1'b0;
            if (scr) begin
                a = $urandom; b = $urandom; acc_in = {$urandom, $urandom};
            end
        end while (!finished && n < 200);
        chk({nm, "_latency"}, 64'(n), 64'd34);
        chk({nm, "_acc_out"}, acc_out, eo);
        chk({nm, "_ovf"}, 64'(ovf), 64'(eovf));
        @(negedge clk);
        arm = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_fin_drop"}, 64'(finished), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] racc, eo, first_out;
        logic        eovf;
        int rises, bad;
        logic prev;

        vt[0] = '{32'd3,          32'hFFFF_FFFB, 64'd10,                  64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
        vt[1] = '{32'h8000_0000,  32'h8000_0000, 64'd0,                   64'h4000_0000_0000_0000, 1'b0};
        vt[2] = '{32'd1,          32'd1,         64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};
        vt[3] = '{32'hFFFF_FFFF,  32'd1,         64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        vt[4] = '{32'd0,          32'd12345,     64'd7,                   64'd7,                   1'b0};
        vt[5] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'd0,                   64'h3FFF_FFFF_0000_0001, 1'b0};
        vt[6] = '{32'h8000_0000,  32'h7FFF_FFFF, 64'd0,                   64'hC000_0000_8000_0000, 1'b0};
        vt[7] = '{32'd5,          32'd0,         64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[8] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1'b0};

        rst_L = 1'b0; arm = 1'b0; a = '0; b = '0; acc_in = '0;
        #1;
        chk("reset_finished", 64'(finished), 64'd0);
        chk("reset_acc_out", acc_out, 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_L = 1'b1;

        for (int i = 0; i < 9; i++)
            do_op(vt[i].a, vt[i].b, vt[i].acc, vt[i].eo, vt[i].eovf, 1'b0, 1'b0, $sformatf("vec%0d", i));

        // operands scrambled during the computation; arm released early
        do_op(vt[0].a, vt[0].b, vt[0].acc, vt[0].eo, vt[0].eovf, 1'b1, 1'b0, "scramble");
        do_op(vt[1].a, vt[1].b, vt[1].acc, vt[1].eo, vt[1].eovf, 1'b1, 1'b1, "drop_arm");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; racc = {$urandom, $urandom};
            if (i % 8 == 0) ra = 32'h8000_0000;
            if (i % 8 == 4) rb = 32'h8000_0000;
            model(ra, rb, racc, eo, eovf);
            do_op(ra, rb, racc, eo, eovf, (i % 2) == 1, (i % 3) == 0, $sformatf("rand%0d", i));
        end

        // arm held high for 100 cycles: exactly one computation, result stable
        ra = 32'h0001_2345; rb = 32'hFFFF_0F00; racc = 64'h0000_0010_0000_0000;
        model(ra, rb, racc, eo, eovf);
        @(negedge clk);
        a = ra; b = rb; acc_in = racc; arm = 1'b1;
        rises = 0; bad = 0; prev = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (finished && !prev) rises++;
            if (finished && acc_out !== eo) bad++;
            prev = finished;
            a = $urandom; b = $urandom; acc_in = {$urandom, $urandom};
        end
        chk("held_rises", 64'(rises), 64'd1);
        chk("held_stable", 64'(bad), 64'd0);
        @(negedge clk);
        arm = 1'b0;
        @(posedge clk);
        #1;
        chk("held_fin_drop", 64'(finished), 64'd0);
        model(32'd1000, 32'd2000, 64'd5, eo, eovf);
        do_op(32'd1000, 32'd2000, 64'd5, eo, eovf, 1'b0, 1'b0, "rearm");

        // reset asserted in the middle of CALC
        @(negedge clk);
        a = 32'd77; b = 32'd99; acc_in = 64'd1; arm = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3;
        rst_L = 1'b0;
        arm = 1'b0;
        #1;
        chk("midrst_finished", 64'(finished), 64'd0);
        chk("midrst_acc_out", acc_out, 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_L = 1'b1;
        bad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (finished) bad++;
        end
        chk("midrst_no_finish", 64'(bad), 64'd0);
        model(32'd77, 32'd99, 64'd1, eo, eovf);
        do_op(32'd77, 32'd99, 64'd1, eo, eovf, 1'b0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mul_accum.md
MUL_ACCUM -- requirements
Module: mul_accum

Interface
REQ-001 SHALL have parameter A_WID, default 32, width of signed multiplicand a.
REQ-002 SHALL have parameter B_WID, default 32, width of signed multiplier b; also the iteration count.
REQ-003 SHALL have parameter ACC_WID, default 64, width of accumulator in/out; feeds the downstream saturator; ACC_WID >= A_WID+B_WID.
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_L, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port arm, input, 1, request a computation; level-held by the requester.
REQ-007 SHALL have port a, input, A_WID, signed multiplicand.
REQ-008 SHALL have port b, input, B_WID, signed multiplier.
REQ-009 SHALL have port acc_in, input, ACC_WID, signed addend.
REQ-010 SHALL have port acc_out, output, ACC_WID, signed result acc_in + a*b, modulo 2^ACC_WID.
REQ-011 SHALL have port ovf, output, 1, signed overflow of the final addition.
REQ-012 SHALL have port finished, output, 1, acc_out/ovf valid.

Function
REQ-013 SHALL implement states WAIT_ARM, CALC, ADD, DONE.
REQ-014 In WAIT_ARM with arm=1, SHALL latch a, b, acc_in and go to CALC; operand changes after this edge have no effect.
REQ-015 At latch, SHALL store |a| and |b| zero-extended by one bit and store sign = a[MSB] XOR b[MSB]; |most-negative| handled without overflow.
REQ-016 In CALC, SHALL perform one unsigned shift-add step per cycle, consuming one bit of |b| LSB-first, for exactly B_WID cycles, then go to ADD.
REQ-017 In ADD, SHALL negate the product if sign=1, sign-extend to ACC_WID, add latched acc_in, register acc_out and ovf, assert finished, and go to DONE.
REQ-018 ovf SHALL be 1 iff both addends have equal sign bits and the sum sign bit differs.
REQ-019 Latency: finished SHALL rise B_WID+2 rising edges after the edge sampling arm=1.
REQ-020 In DONE, finished, acc_out and ovf SHALL hold until arm=0 is sampled; then finished drops and state returns to WAIT_ARM on that edge.
REQ-021 arm held high continuously SHALL NOT start a second computation; a new one needs arm low for at least one sampled edge.
REQ-022 arm deasserted during CALC/ADD SHALL NOT abort; the computation completes and DONE exits on the first edge with arm=0.
REQ-023 acc_out and ovf SHALL change only on the ADD->DONE edge and on reset.
REQ-024 b=0 or a=0 SHALL still take the full B_WID+2 latency.

Reset
REQ-025 On rst_L=0, SHALL immediately, without waiting for clk, set state WAIT_ARM, finished=0, ovf=0, acc_out=0, and clear internal product, counter and operand registers.
REQ-026 Reset mid-computation SHALL discard all progress; after rst_L=1, the block SHALL start only on a fresh arm=1 sample.

Verification (A_WID=B_WID=32, ACC_WID=64)
REQ-027 a=3, b=-5, acc_in=10, arm pulse held -> finished exactly 34 edges after arm sampled; acc_out=-5; ovf=0.
REQ-028 a=b=-2^31, acc_in=0 -> acc_out=2^62 (0x4000_0000_0000_0000); ovf=0.
REQ-029 a=1, b=1, acc_in=2^63-1 -> acc_out=0x8000_0000_0000_0000, ovf=1; a=-1, b=1, acc_in=-2^63 -> acc_out=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
REQ-030 arm held high 100 cycles -> exactly one finished assertion; acc_out stable; arm low then high -> second computation with newly latched operands.
REQ-031 rst_L pulsed low at CALC cycle 10 -> finished=0 and acc_out=0 asynchronously; no finished until the next arm sample plus 34 edges.
REQ-032 Operands changed every cycle during CALC -> result equals product of values latched at arm sample.
